// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register family.
// Also holds the EX/MEM control/data bundle layouts and their pack/unpack helpers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int unsigned CTRL_W_EXMEM = 11;
    localparam int unsigned DATA_W_EXMEM = 101;

    // EX/MEM control bundle bit positions, MSB first
    localparam int unsigned CTRL_REGWRITE_OFF  = 10;
    localparam int unsigned CTRL_MEMTOREG_OFF  = 9;
    localparam int unsigned CTRL_LSEL_OFF      = 6;
    localparam int unsigned CTRL_LSEL_W        = 3;
    localparam int unsigned CTRL_SSEL_OFF      = 4;
    localparam int unsigned CTRL_SSEL_W        = 2;
    localparam int unsigned CTRL_MEMWRITE_OFF  = 3;
    localparam int unsigned CTRL_MEMREAD_OFF   = 2;
    localparam int unsigned CTRL_WE_OFF        = 1;
    localparam int unsigned CTRL_WDSEL_OFF     = 0;

    localparam int unsigned DATA_ALU_OFF       = 69;
    localparam int unsigned DATA_FWDB_OFF      = 37;
    localparam int unsigned DATA_REGDST_OFF    = 32;
    localparam int unsigned DATA_PCP4_OFF      = 0;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic [2:0] lsel;
        logic [1:0] ssel;
        logic       mem_write;
        logic       mem_read;
        logic       write_enable;
        logic       write_data_sel;
    } exmem_ctrl_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] forward_mux_b;
        logic [4:0]  reg_dst;
        logic [31:0] pc_plus4;
    } exmem_data_t;

    function automatic logic [CTRL_W_EXMEM-1:0] pack_exmem_ctrl(input exmem_ctrl_t c);
        return CTRL_W_EXMEM'(c);
    endfunction

    function automatic exmem_ctrl_t unpack_exmem_ctrl(input logic [CTRL_W_EXMEM-1:0] v);
        return exmem_ctrl_t'(v);
    endfunction

    function automatic logic [DATA_W_EXMEM-1:0] pack_exmem_data(input exmem_data_t d);
        return DATA_W_EXMEM'(d);
    endfunction

    function automatic exmem_data_t unpack_exmem_data(input logic [DATA_W_EXMEM-1:0] v);
        return exmem_data_t'(v);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional 2-entry skid buffer,
// synchronous flush with bubble insertion and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_EXMEM,
    parameter int unsigned DATA_W = DATA_W_EXMEM,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state, state_n;
    logic [CTRL_W-1:0] m_ctrl, m_ctrl_n, s_ctrl, s_ctrl_n;
    logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
    logic              valid_q, valid_n;
    logic              rdy_q, rdy_n;
    logic              accept, pop;
    logic              stall_inc;

    // Registered ready in skid mode; otherwise ready passes straight through from downstream
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = rdy_q;
        end else begin : g_noskid
            assign in_ready = ~valid_q | out_ready;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign pop    = valid_q & out_ready;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_EMPTY;
            m_ctrl  <= '0;
            m_data  <= '0;
            s_ctrl  <= '0;
            s_data  <= '0;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state   <= state_n;
            m_ctrl  <= m_ctrl_n;
            m_data  <= m_data_n;
            s_ctrl  <= s_ctrl_n;
            s_data  <= s_data_n;
            valid_q <= valid_n;
            rdy_q   <= rdy_n;
        end
    end

    // Next state; every transition into EMPTY zeroes the control bundle so bubbles are inert
    always_comb begin
        state_n  = state;
        m_ctrl_n = m_ctrl;
        m_data_n = m_data;
        s_ctrl_n = s_ctrl;
        s_data_n = s_data;

        if (flush) begin
            state_n  = ST_EMPTY;
            m_ctrl_n = '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_n  = ST_ONE;
                        m_ctrl_n = in_ctrl;
                        m_data_n = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        m_ctrl_n = in_ctrl;
                        m_data_n = in_data;
                    end else if (accept) begin
                        if (SKID != 0) begin
                            state_n  = ST_FULL;
                            s_ctrl_n = in_ctrl;
                            s_data_n = in_data;
                        end
                    end else if (pop) begin
                        state_n  = ST_EMPTY;
                        m_ctrl_n = '0;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_n  = ST_ONE;
                        m_ctrl_n = s_ctrl;
                        m_data_n = s_data;
                    end
                end
                default: begin
                    state_n  = ST_EMPTY;
                    m_ctrl_n = '0;
                end
            endcase
        end

        valid_n = (state_n != ST_EMPTY);
        rdy_n   = (state_n != ST_FULL);
    end

    assign out_valid = valid_q;
    assign out_ctrl  = m_ctrl;
    assign out_data  = m_data;

    assign stall_inc = valid_q & ~out_ready;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .Clk  (Clk),
        .Rst  (Rst),
        .inc  (stall_inc),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a no-skid/3-bit-counter instance share
// stimulus; each is checked against a capacity-limited FIFO reference model.
module tb_pipe_stage_reg;

    localparam int unsigned CW    = 11;
    localparam int unsigned DW    = 101;
    localparam int unsigned MAX1  = 65535;
    localparam int unsigned MAX0  = 7;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          in_ready1, out_valid1;
    logic [CW-1:0] out_ctrl1;
    logic [DW-1:0] out_data1;
    logic [15:0]   stall_cnt1;

    logic          in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl0;
    logic [DW-1:0] out_data0;
    logic [2:0]    stall_cnt0;

    int checks = 0;
    int errors = 0;

    ent_t        q1[$];
    ent_t        q0[$];
    int unsigned cnt1 = 0;
    int unsigned cnt0 = 0;
    bit          rdy1, rdy0;

    always #5 Clk = ~Clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut_skid (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .stall_cnt(stall_cnt1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CNT_W(3)) dut_noskid (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .stall_cnt(stall_cnt0)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid); flush empties it
    always @(posedge Clk) begin
        rdy1 = (q1.size() < 2);
        rdy0 = (q0.size() == 0) || out_ready;
        if (Rst) begin
            q1.delete();
            q0.delete();
            cnt1 = 0;
            cnt0 = 0;
        end else begin
            if (q1.size() != 0 && !out_ready && cnt1 < MAX1) cnt1++;
            if (q0.size() != 0 && !out_ready && cnt0 < MAX0) cnt0++;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() != 0 && out_ready) void'(q1.pop_front());
                if (q0.size() != 0 && out_ready) void'(q0.pop_front());
                if (in_valid && rdy1) q1.push_back('{c: in_ctrl, d: in_data});
                if (in_valid && rdy0) q0.push_back('{c: in_ctrl, d: in_data});
            end
        end
    end

    // Monitor: compare presented outputs against the head of each expected queue
    always @(negedge Clk) begin
        check("skid_out_valid", 128'(out_valid1), 128'(q1.size() != 0));
        check("skid_in_ready", 128'(in_ready1), 128'(q1.size() < 2));
        check("skid_stall_cnt", 128'(stall_cnt1), 128'(cnt1));
        if (q1.size() != 0) begin
            check("skid_out_ctrl", 128'(out_ctrl1), 128'(q1[0].c));
            check("skid_out_data", 128'(out_data1), 128'(q1[0].d));
        end else begin
            check("skid_bubble_ctrl", 128'(out_ctrl1), 128'(0));
        end

        check("noskid_out_valid", 128'(out_valid0), 128'(q0.size() != 0));
        check("noskid_in_ready", 128'(in_ready0), 128'((q0.size() == 0) || out_ready));
        check("noskid_stall_cnt", 128'(stall_cnt0), 128'(cnt0));
        if (q0.size() != 0) begin
            check("noskid_out_ctrl", 128'(out_ctrl0), 128'(q0[0].c));
            check("noskid_out_data", 128'(out_data0), 128'(q0[0].d));
        end else begin
            check("noskid_bubble_ctrl", 128'(out_ctrl0), 128'(0));
        end
    end

    task automatic step();
        @(negedge Clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [DW-1:0] d);
        in_valid = v;
        in_ctrl  = CW'($urandom);
        in_data  = d;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return DW'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    initial begin
        Rst       = 1'b1;
        in_valid  = 1'b1;
        in_ctrl   = 11'h7FF;
        in_data   = rnd_data();
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge Clk);
        step();
        Rst = 1'b0;
        present(1'b0, '0);
        step();

        // Streaming with downstream always ready
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            present(1'b1, DW'(i));
            step();
        end
        present(1'b0, '0);
        repeat (3) step();

        // Back-to-back A,B into a stalled stage, then drain
        out_ready = 1'b0;
        present(1'b1, rnd_data());
        step();
        present(1'b1, rnd_data());
        step();
        present(1'b0, '0);
        repeat (2) step();
        out_ready = 1'b1;
        repeat (3) step();

        // Fill again and flush while an entry C is offered
        out_ready = 1'b0;
        present(1'b1, rnd_data());
        step();
        present(1'b1, rnd_data());
        step();
        present(1'b1, 101'hC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        present(1'b0, '0);
        repeat (2) step();

        // Fresh reset, then a long stall to reach saturation on the narrow counter
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        present(1'b1, rnd_data());
        step();
        present(1'b0, '0);
        repeat (10) step();
        out_ready = 1'b1;
        repeat (2) step();

        // Downstream ready toggling every cycle under continuous offers
        for (int i = 0; i < 20; i++) begin
            out_ready = i[0];
            present(1'b1, rnd_data());
            step();
        end

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            present(($urandom % 4) != 0, rnd_data());
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 32) == 0;
            Rst       = ($urandom % 100) == 0;
            step();
        end
        Rst   = 1'b0;
        flush = 1'b0;

        present(1'b0, '0);
        out_ready = 1'b1;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
